instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-side counterpart of the control unit: owns the PC, fetches 32-bit words from instruction
//  memory over a req/rvalid handshake and presents Instr to the decoder with a valid/ready handshake.
//  Consumes PCSrc and the extended immediate to pick the next PC (PC+4 or PC+imm).
//  Sits between instruction memory and Control_Unit/datapath; allows multi-cycle memory latency.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; first fetch address
//  NOP_INSTR  32'h0000_0013  value driven on instr while no valid word (addi x0,x0,0)
// PORTS
//  clk           in   1   rising-edge clock
//  rst_n         in   1   synchronous reset, active-low
//  imem_req      out  1   one-cycle fetch request pulse
//  imem_addr     out  32  fetch address (= pc), stable from request until rvalid
//  imem_rvalid   in   1   read data valid, sampled only in S_WAIT
//  imem_rdata    in   32  instruction word
//  instr_valid   out  1   instr/pc hold a fetched instruction
//  instr_ready   in   1   core consumes instruction this cycle (commit)
//  instr         out  32  instruction to Control_Unit
//  pc            out  32  address of instr
//  pc_plus4      out  32  pc + 4 (link value)
//  pc_src        in   1   Control_Unit PCSrc, sampled at commit
//  imm_ext       in   32  sign-extended branch/jump offset, sampled at commit
//  fetch_trap    out  1   misaligned-target trap (feature-gated, else tied 0)
//  instr_count   out  32  committed-instruction counter
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=S_REQ, pc=RESET_PC, imem_req=0, instr_valid=0,
//    instr=NOP_INSTR, fetch_trap=0, instr_count=0. Reset wins over every other event, any state.
//  - States: S_REQ -> S_WAIT -> S_HOLD -> S_REQ (S_TRAP with feature only).
//  - S_REQ: imem_req=1 for exactly this cycle, imem_addr=pc; next S_WAIT.
//  - S_WAIT: imem_req=0; on imem_rvalid=1 register imem_rdata into instr, set instr_valid=1, go
//    S_HOLD. rvalid in any other state is ignored. No timeout; waits indefinitely.
//  - S_HOLD: instr, pc, pc_plus4 stable while instr_valid=1 and instr_ready=0.
//    Commit = instr_valid & instr_ready: next_pc = pc_src ? pc + imm_ext : pc + 4 (mod 2^32,
//    wraps silently); pc<=next_pc, instr_valid<=0, instr<=NOP_INSTR, instr_count+=1
//    (wraps 2^32-1 -> 0); next S_REQ.
//  - Latency: commit at cycle N -> imem_req at N+1; rvalid at cycle M -> instr_valid at M+1.
//    Min throughput one instruction per 3 cycles (1-cycle memory).
//  - pc_src/imm_ext ignored outside commit cycle; instr_ready ignored while instr_valid=0.
//  - pc_plus4 = pc + 4 combinationally, always.
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined: at commit, if next_pc[1:0]!=2'b00, pc<=next_pc,
//    instr_count still increments, state->S_TRAP: fetch_trap=1, imem_req=0, instr_valid=0;
//    held until reset.
//  Not defined: next_pc[1:0] forced to 2'b00 before loading pc; S_TRAP unreachable;
//    fetch_trap tied 0.
// TESTING
//  1 Reset then release -> imem_req=1, imem_addr=RESET_PC on first cycle; all outputs at reset values before.
//  2 Memory returns 32'h00500093 two cycles after req, instr_ready=1 -> instr_valid next cycle,
//    instr=32'h00500093; commit with pc_src=0 -> next req at pc=4, instr_count=1.
//  3 pc=0x40, commit pc_src=1, imm_ext=32'hFFFF_FFF8 -> next imem_addr=0x38; pc_src=1 at non-commit ignored.
//  4 instr_ready low 5 cycles in S_HOLD -> instr/pc stable, no imem_req, count unchanged;
//    stray rvalid ignored.
//  5 rst_n=0 during S_WAIT, then rvalid -> pc=RESET_PC, instr_valid=0, rvalid ignored, fresh req.
//  6 pc=0xFFFF_FFFC commit pc_src=0 -> pc=0 (wrap). imm_ext=2: macro on -> fetch_trap=1, no req;
//    macro off -> next imem_addr=pc+0 (aligned).

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/rvalid handshake and hands them to the decoder.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: misaligned next PC traps instead of being force-aligned.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        pc_src,
    input  logic [31:0] imm_ext,
    output logic        fetch_trap,
    output logic [31:0] instr_count
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;

    state_t      state_q;
    logic [31:0] pc_q, instr_q, count_q;
    logic        req_q, valid_q, trap_q;

    logic        commit;
    logic        misalign;
    logic [31:0] next_pc_raw, next_pc;

    assign commit      = (state_q == S_HOLD) && valid_q && instr_ready;
    assign next_pc_raw = pc_src ? (pc_q + imm_ext) : (pc_q + 32'd4);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign next_pc  = next_pc_raw;
    assign misalign = |next_pc_raw[1:0];
`else
    assign next_pc  = {next_pc_raw[31:2], 2'b00};
    assign misalign = 1'b0;
`endif

    // S_REQ with req_q low only happens right after reset: raise the request one cycle later
    // so every output holds its reset value while rst_n is asserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            count_q <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_q) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end else begin
                        req_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        instr_q <= imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (commit) begin
                        pc_q    <= next_pc;
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                        count_q <= count_q + 32'd1;
                        if (misalign) begin
                            trap_q  <= 1'b1;
                            state_q <= S_TRAP;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= S_REQ;
                        end
                    end
                end
                S_TRAP: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fetch_trap  = trap_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; expected values are hand-computed constants.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_src;
    logic [31:0] imm_ext;
    logic        fetch_trap;
    logic [31:0] instr_count;

    int n_chk  = 0;
    int n_fail = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .pc_src      (pc_src),
        .imm_ext     (imm_ext),
        .fetch_trap  (fetch_trap),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the request cycle; leaves in the cycle after commit.
    // pc_src/imm_ext are driven with noise during the wait cycle to show they are ignored.
    task automatic fetch_commit(input logic [31:0] rdata, input logic src, input logic [31:0] imm);
        tick();
        pc_src = 1'b1; imm_ext = 32'h0000_0100;
        imem_rvalid = 1'b1; imem_rdata = rdata;
        tick();
        imem_rvalid = 1'b0;
        instr_ready = 1'b1; pc_src = src; imm_ext = imm;
        tick();
        instr_ready = 1'b0; pc_src = 1'b0; imm_ext = 32'd0;
    endtask

    initial begin
        rst_n = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        instr_ready = 1'b0; pc_src = 1'b0; imm_ext = 32'd0;
        tick(); tick();

        // reset state
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr,                NOP);
        chk("rst_trap",  {31'd0, fetch_trap},  32'd0);
        chk("rst_count", instr_count,          32'd0);
        chk("rst_pc",    pc,                   32'd0);
        chk("rst_pc4",   pc_plus4,             32'd4);

        // first request after release
        rst_n = 1'b1;
        tick();
        chk("t1_req",  {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr,         32'd0);

        // memory answers two cycles after the request
        tick();
        chk("t2_req_pulse", {31'd0, imem_req}, 32'd0);
        chk("t2_addr_hold", imem_addr,         32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 1'b0;
        chk("t2_valid", {31'd0, instr_valid}, 32'd1);
        chk("t2_instr", instr,                32'h0050_0093);
        chk("t2_pc",    pc,                   32'd0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t2_req_next", {31'd0, imem_req}, 32'd1);
        chk("t2_addr",     imem_addr,         32'd4);
        chk("t2_count",    instr_count,       32'd1);
        chk("t2_valid0",   {31'd0, instr_valid}, 32'd0);
        chk("t2_nop",      instr,             NOP);

        // jump to 0x40, then branch back by 8
        fetch_commit(32'h0000_0001, 1'b1, 32'h0000_003C);
        chk("t3_addr40", imem_addr, 32'h40);
        chk("t3_req40",  {31'd0, imem_req}, 32'd1);
        fetch_commit(32'h0000_0002, 1'b1, 32'hFFFF_FFF8);
        chk("t3_addr38", imem_addr,   32'h38);
        chk("t3_count",  instr_count, 32'd3);

        // decoder stalls five cycles, with a stray rvalid in the middle
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678; end
            else imem_rvalid = 1'b0;
            pc_src = 1'b1; imm_ext = 32'h0000_0200;
            tick();
            chk("t4_valid", {31'd0, instr_valid}, 32'd1);
            chk("t4_instr", instr,                32'hDEAD_BEEF);
            chk("t4_pc",    pc,                   32'h38);
            chk("t4_req",   {31'd0, imem_req},    32'd0);
            chk("t4_count", instr_count,          32'd3);
        end
        imem_rvalid = 1'b0; pc_src = 1'b0; imm_ext = 32'd0;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("t4_addr", imem_addr,   32'h3C);
        chk("t4_cnt4", instr_count, 32'd4);

        // reset while waiting on memory; late rvalid must be ignored
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0000_AAAA;
        chk("t5_pc",    pc,                   32'd0);
        chk("t5_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_req",   {31'd0, imem_req},    32'd0);
        chk("t5_count", instr_count,          32'd0);
        tick();
        imem_rvalid = 1'b0;
        chk("t5_req1",  {31'd0, imem_req},    32'd1);
        chk("t5_addr",  imem_addr,            32'd0);
        chk("t5_valid1",{31'd0, instr_valid}, 32'd0);
        chk("t5_nop",   instr,                NOP);

        // PC wrap at top of address space, then misaligned target
        fetch_commit(32'h0000_0003, 1'b1, 32'hFFFF_FFFC);
        chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
        chk("t6_pc4_wrap", pc_plus4,  32'd0);
        fetch_commit(32'h0000_0004, 1'b0, 32'd0);
        chk("t6_wrap",   imem_addr,   32'd0);
        chk("t6_count2", instr_count, 32'd2);
        fetch_commit(32'h0000_0005, 1'b1, 32'd2);
        chk("t6_count3", instr_count, 32'd3);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t6_trap",  {31'd0, fetch_trap},  32'd1);
        chk("t6_noreq", {31'd0, imem_req},    32'd0);
        chk("t6_pc",    pc,                   32'd2);
        tick(); tick();
        chk("t6_trap_hold", {31'd0, fetch_trap}, 32'd1);
        chk("t6_noreq2",    {31'd0, imem_req},   32'd0);
        chk("t6_valid0",    {31'd0, instr_valid}, 32'd0);
`else
        chk("t6_notrap", {31'd0, fetch_trap}, 32'd0);
        chk("t6_req",    {31'd0, imem_req},   32'd1);
        chk("t6_align",  imem_addr,           32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
